// File: rtl/clk_div_prog.sv
// clk_div_prog -- runtime-programmable integer clock divider.
//
// Divides clk by any ratio N in 2..2^W-1. A new ratio is requested with
// div_load/div_val and takes effect at the next period boundary, so the
// divided clock never glitches. div_tick marks the first clk cycle of each
// period, and div_ack marks the period in which a new ratio took effect.
//
// Optional feature macro: CLK_DIV_DUTY50_EN
//   defined   -> adds a negedge phase register so odd ratios get 50% duty
//   undefined -> odd N gives floor(N/2) cycles high, ceil(N/2) cycles low
//
// Parameters:
//   W        width of ratio, counter and div_cur
//   DEF_DIV  ratio in force after reset (2..2^W-1)
//
// Ports:
//   clk       in   source clock
//   rst       in   asynchronous active-low reset
//   en        in   run enable
//   div_val   in   requested ratio N
//   div_load  in   one-cycle load request for div_val
//   div_ack   out  one-cycle pulse, new ratio took effect
//   div_err   out  one-cycle pulse, load rejected (div_val < 2)
//   div_cur   out  ratio currently in force
//   div_clk   out  divided clock
//   div_tick  out  high for the first clk cycle of each period

module clk_div_prog #(
    parameter int W       = 16,
    parameter int DEF_DIV = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         div_ack,
    output logic         div_err,
    output logic [W-1:0] div_cur,
    output logic         div_clk,
    output logic         div_tick
);

    logic [W-1:0] cur;
    logic [W-1:0] cnt;
    logic [W-1:0] pend;
    logic         pend_v;
    logic         run;
    logic         pos_q;
    logic         tick;
    logic         ack;
    logic         err;

    logic         load_ok;
    logic         load_bad;
    logic         wrap;
    logic         apply_v;
    logic [W-1:0] apply_val;
    logic [W-1:0] half;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] cur_m1;

    // Decode the load request and the period position. A load sampled on
    // the same edge as a wrap beats anything already buffered, so the
    // newest request always wins.
    always_comb begin
        load_ok   = 1'b0;
        load_bad  = 1'b0;
        cur_m1    = cur - W'(1);
        cnt_inc   = cnt + W'(1);
        half      = cur >> 1;
        wrap      = 1'b0;
        apply_v   = 1'b0;
        apply_val = cur;

        load_ok   = div_load && (div_val >= W'(2));
        load_bad  = div_load && (div_val <  W'(2));
        wrap      = (cnt == cur_m1);
        apply_v   = load_ok || pend_v;
        apply_val = load_ok ? div_val : pend;
    end

    // Main divider state. Disable has top priority and applies any pending
    // ratio at once; a restart always begins a fresh period with a tick;
    // a running divider only switches ratio at the wrap so the output
    // waveform stays glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur    <= W'(DEF_DIV);
            cnt    <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            run    <= 1'b0;
            pos_q  <= 1'b0;
            tick   <= 1'b0;
            ack    <= 1'b0;
            err    <= 1'b0;
        end else begin
            err  <= load_bad;
            ack  <= 1'b0;
            tick <= 1'b0;
            if (!en) begin
                run    <= 1'b0;
                cnt    <= '0;
                pos_q  <= 1'b0;
                pend_v <= 1'b0;
                if (apply_v) begin
                    cur <= apply_val;
                    ack <= 1'b1;
                end
            end else if (!run) begin
                run   <= 1'b1;
                cnt   <= '0;
                pos_q <= 1'b1;
                tick  <= 1'b1;
                if (load_ok) begin
                    pend   <= div_val;
                    pend_v <= 1'b1;
                end
            end else if (wrap) begin
                cnt    <= '0;
                pos_q  <= 1'b1;
                tick   <= 1'b1;
                pend_v <= 1'b0;
                if (apply_v) begin
                    cur <= apply_val;
                    ack <= 1'b1;
                end
            end else begin
                cnt   <= cnt_inc;
                pos_q <= (cnt_inc < half);
                if (load_ok) begin
                    pend   <= div_val;
                    pend_v <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic neg_q;

    // Half-cycle extension for odd ratios: copying pos_q on the falling
    // edge stretches the high phase by half a clk cycle. pos_q is always
    // low in the last cycle of a period, so neg_q is low there too and a
    // ratio change cannot produce a glitch.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & cur[0];
        end
    end

    assign div_clk = pos_q | neg_q;
`else
    assign div_clk = pos_q;
`endif

    assign div_tick = tick;
    assign div_ack  = ack;
    assign div_err  = err;
    assign div_cur  = cur;

endmodule
